dmem_miss_ctrl: RTL

Data-memory controller sitting directly downstream of the direct-mapped data cache: it services load misses by fetching the word from main memory, returns it as fill data for the cache and the load result, and posts all stores (write-through) into a small write buffer that drains to memory in the background. It owns the pipeline stall for the memory stage and the only handshake to the main-memory port.

---
 rtl/dmem_miss_ctrl_pkg.sv | 27 ++
 rtl/dmem_wbuf.sv | 80 ++++++++
 rtl/dmem_miss_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_miss_ctrl_pkg.sv
// Shared types for the data-memory miss controller: FSM states, memory-stage
// opcodes and the default write-buffer depth.
package dmem_miss_ctrl_pkg;

  localparam int unsigned WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_FILL = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mem_op_e;

  // A simultaneous load and store is illegal; the load takes precedence.
  function automatic mem_op_e decode_op(input logic ld, input logic st);
    if (ld)      return OP_LOAD;
    else if (st) return OP_STORE;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Circular write-buffer FIFO with wrap-bit pointers and a per-entry address
// compare that returns the youngest matching entry's data.
module dmem_wbuf
  import dmem_miss_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = WBUF_DEPTH_DEF,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [ADDR_W-1:0]         push_addr_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [ADDR_W-1:0]         head_addr_o,
  output logic [DATA_W-1:0]         head_data_o,
  input  logic [ADDR_W-1:0]         cmp_addr_i,
  output logic                      match_o,
  output logic [DATA_W-1:0]         match_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]       head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push_ok, pop_ok;
  logic [PW-1:0]     idx;

  assign count_o     = tail_q - head_q;
  assign empty_o     = (head_q == tail_q);
  assign full_o      = (count_o == (PW+1)'(DEPTH));
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign head_addr_o = addr_q[head_q[PW-1:0]];
  assign head_data_o = data_q[head_q[PW-1:0]];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_ok)  head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_q[tail_q[PW-1:0]] <= push_addr_i;
      data_q[tail_q[PW-1:0]] <= push_data_i;
    end
  end

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    match_o      = 1'b0;
    match_data_o = '0;
    idx          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q[PW-1:0] + PW'(i);
      if ((i < 32'(count_o)) && (addr_q[idx] == cmp_addr_i)) begin
        match_o      = 1'b1;
        match_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_miss_ctrl.sv
// Data-memory miss controller: services load misses from main memory and
// drains write-through stores via dmem_wbuf. Optional store-to-load
// forwarding from the write buffer is enabled by MEMCTRL_WBUF_FWD_EN.
module dmem_miss_ctrl
  import dmem_miss_ctrl_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ld_req,
  input  logic                          st_req,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             st_data,
  input  logic                          hit,
  output logic                          stall,
  output logic                          fill_valid,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifndef MEMCTRL_WBUF_FWD_EN
  logic              drain_q, drain_d;
`endif

  mem_op_e           op;
  logic              ld_miss, st_op;
  logic              stall_c, fill_valid_c, fwd_c, pop;
  logic              wb_full, wb_empty, wb_match;
  logic [ADDR_W-1:0] wb_head_addr;
  logic [DATA_W-1:0] wb_head_data, wb_match_data;

  assign op      = decode_op(ld_req, st_req);
  assign ld_miss = (op == OP_LOAD) && !hit;
  assign st_op   = (op == OP_STORE);

  dmem_wbuf #(
    .DEPTH  (WBUF_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_i       (st_op && !wb_full),
    .push_addr_i  (addr),
    .push_data_i  (st_data),
    .pop_i        (pop),
    .full_o       (wb_full),
    .empty_o      (wb_empty),
    .count_o      (wbuf_count),
    .head_addr_o  (wb_head_addr),
    .head_data_o  (wb_head_data),
    .cmp_addr_i   (addr),
    .match_o      (wb_match),
    .match_data_o (wb_match_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    stall_c      = st_op && wb_full;
    fill_valid_c = 1'b0;
    fwd_c        = 1'b0;
    pop          = 1'b0;
`ifndef MEMCTRL_WBUF_FWD_EN
    drain_d      = drain_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_miss) begin
`ifdef MEMCTRL_WBUF_FWD_EN
          if (wb_match) begin
            fill_valid_c = 1'b1;
            fwd_c        = 1'b1;
          end else begin
            stall_c    = 1'b1;
            state_d    = ST_RD;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr;
          end
`else
          stall_c = 1'b1;
          // Once a match is seen, keep draining until the buffer is empty.
          if (!wb_empty && (wb_match || drain_q)) begin
            drain_d     = 1'b1;
            state_d     = ST_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_head_addr;
            mem_wdata_d = wb_head_data;
          end else begin
            drain_d    = 1'b0;
            state_d    = ST_RD;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr;
          end
`endif
        end else begin
`ifndef MEMCTRL_WBUF_FWD_EN
          drain_d = 1'b0;
`endif
          if (!wb_empty) begin
            state_d     = ST_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_head_addr;
            mem_wdata_d = wb_head_data;
          end
        end
      end
      ST_RD: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_valid_c = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_WR: begin
        if (ld_miss) stall_c = 1'b1;
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifndef MEMCTRL_WBUF_FWD_EN
      drain_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifndef MEMCTRL_WBUF_FWD_EN
      drain_q     <= drain_d;
`endif
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall      = stall_c && reset;
  assign fill_valid = fill_valid_c && reset;
  assign fill_data  = fwd_c ? wb_match_data : rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
